// File: rtl/key_pkg.sv
// Shared types and constants for push-button debouncing.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE_UP   = 2'd0,
      DEB_DOWN  = 2'd1,
      HELD_DOWN = 2'd2,
      DEB_UP    = 2'd3
   } key_state_t;

   localparam int unsigned KEY_CNT_20MS_50MHZ = 1_000_000;

   // Buttons are active-low at the pin.
   localparam logic KEY_PRESSED  = 1'b0;
   localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input; reset value selectable.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Active-low key debouncer: a new level is accepted after CNT_MAX stable cycles
// and every accepted change is reported with a one-cycle key_flag pulse.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned CNT_MAX = KEY_CNT_20MS_50MHZ
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_in,
   output logic       key_value,
   output logic       key_flag,
   output key_state_t dbg_state_o
);

   localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

   logic             key_s;
   key_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             key_value_q;
   logic             key_flag_q;

   sync_2ff #(
      .RST_VAL (KEY_RELEASED)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (key_in),
      .q_o (key_s)
   );

   // Flag defaults low every cycle, so it can never stay high two cycles running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE_UP;
         cnt_q       <= '0;
         key_value_q <= KEY_RELEASED;
         key_flag_q  <= 1'b0;
      end else begin
         key_flag_q <= 1'b0;
         unique case (state_q)
            IDLE_UP: begin
               if (key_s == KEY_PRESSED) begin
                  state_q <= DEB_DOWN;
                  cnt_q   <= '0;
               end
            end
            DEB_DOWN: begin
               if (key_s == KEY_RELEASED) begin
                  state_q <= IDLE_UP;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q     <= HELD_DOWN;
                  cnt_q       <= '0;
                  key_value_q <= KEY_PRESSED;
                  key_flag_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            HELD_DOWN: begin
               if (key_s == KEY_RELEASED) begin
                  state_q <= DEB_UP;
                  cnt_q   <= '0;
               end
            end
            DEB_UP: begin
               if (key_s == KEY_PRESSED) begin
                  state_q <= HELD_DOWN;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q     <= IDLE_UP;
                  cnt_q       <= '0;
                  key_value_q <= KEY_RELEASED;
                  key_flag_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE_UP;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign key_value   = key_value_q;
   assign key_flag    = key_flag_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX = 4 (accept on edge 7 after a pin change).
module tb_key_debounce;
   import key_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_in = 1'b0;
   logic       key_value;
   logic       key_flag;
   key_state_t dbg_state;

   int checks = 0;
   int errors = 0;

   int   flags;
   int   toggles;
   logic toggle_q;
   logic prev_flag;
   logic lvl [0:1];

   key_debounce #(
      .CNT_MAX (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .key_value   (key_value),
      .key_flag    (key_flag),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic val, input logic flg);
      check({tag, "_value"}, 8'(key_value), 8'(val));
      check({tag, "_flag"}, 8'(key_flag), 8'(flg));
   endtask

   // Pin already changed before this call: edges 1..6 quiet, edge 7 accepts, edge 8 flag drops.
   task automatic expect_accept(input string tag, input logic old_val, input logic new_val);
      for (int i = 1; i <= 6; i++) begin
         step();
         check_out({tag, "_wait"}, old_val, 1'b0);
      end
      step();
      check_out({tag, "_edge7"}, new_val, 1'b1);
      step();
      check_out({tag, "_edge8"}, new_val, 1'b0);
   endtask

   initial begin
      // Reset with the pin held pressed
      rst    = 1'b1;
      key_in = 1'b0;
      repeat (3) step();
      check_out("in_reset", 1'b1, 1'b0);
      check("in_reset_state", 8'(dbg_state), 8'(IDLE_UP));
      rst = 1'b0;
      check_out("post_reset", 1'b1, 1'b0);
      expect_accept("reset_press", 1'b1, 1'b0);

      // Release
      key_in = 1'b1;
      expect_accept("release", 1'b0, 1'b1);

      // Clean press and release
      key_in = 1'b0;
      expect_accept("clean_press", 1'b1, 1'b0);
      key_in = 1'b1;
      repeat (10) step();
      check_out("clean_release_done", 1'b1, 1'b0);

      // Bounce: low 3, high 1, then low steadily
      key_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out("bounce_low", 1'b1, 1'b0);
      end
      key_in = 1'b1;
      step();
      check_out("bounce_high", 1'b1, 1'b0);
      key_in = 1'b0;
      expect_accept("bounce_settle", 1'b1, 1'b0);
      key_in = 1'b1;
      repeat (10) step();
      check_out("bounce_release_done", 1'b1, 1'b0);

      // Glitch rejection: 1-, 2- and 3-cycle low pulses
      for (int len = 1; len <= 3; len++) begin
         key_in = 1'b0;
         for (int i = 0; i < len; i++) begin
            step();
            check_out("glitch_low", 1'b1, 1'b0);
         end
         key_in = 1'b1;
         for (int i = 0; i < 10; i++) begin
            step();
            check_out("glitch_after", 1'b1, 1'b0);
         end
      end

      // Press held 20 cycles then released, with a toggling consumer
      flags     = 0;
      toggles   = 0;
      toggle_q  = 1'b0;
      prev_flag = 1'b0;
      lvl[0]    = 1'bx;
      lvl[1]    = 1'bx;
      for (int i = 0; i < 40; i++) begin
         key_in = (i < 20) ? 1'b0 : 1'b1;
         step();
         check("pair_no_double_flag", 8'(prev_flag & key_flag), 8'd0);
         if (key_flag) begin
            if (flags < 2) lvl[flags] = key_value;
            flags++;
            if (key_value == KEY_PRESSED) begin
               toggle_q = ~toggle_q;
               toggles++;
            end
         end
         prev_flag = key_flag;
      end
      check("pair_flag_count", 8'(flags), 8'd2);
      check("pair_first_level", 8'(lvl[0]), 8'd0);
      check("pair_second_level", 8'(lvl[1]), 8'd1);
      check("pair_toggles", 8'(toggles), 8'd1);
      check("pair_toggle_state", 8'(toggle_q), 8'd1);
      check_out("pair_end", 1'b1, 1'b0);

      // Reset mid-qualification: DEB_DOWN with counter 2 after edge 5
      key_in = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         check_out("midq_wait", 1'b1, 1'b0);
      end
      check("midq_state", 8'(dbg_state), 8'(DEB_DOWN));
      #1;
      rst = 1'b1;
      #1;
      check_out("midq_async", 1'b1, 1'b0);
      check("midq_async_state", 8'(dbg_state), 8'(IDLE_UP));
      step();
      rst = 1'b0;
      step();
      check_out("midq_after_release", 1'b1, 1'b0);
      for (int i = 2; i <= 6; i++) begin
         step();
         check_out("midq_requal_wait", 1'b1, 1'b0);
      end
      step();
      check_out("midq_requal_edge7", 1'b0, 1'b1);
      step();
      check_out("midq_requal_edge8", 1'b0, 1'b0);

      // Reset while held down drives the level back to released at once
      check("held_state", 8'(dbg_state), 8'(HELD_DOWN));
      #1;
      rst = 1'b1;
      #1;
      check_out("held_async", 1'b1, 1'b0);
      step();
      rst    = 1'b0;
      key_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_out("held_after_release", 1'b1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces one raw, active-low push-button input and produces the `key_value` / `key_flag` pair that key-driven control blocks consume. The raw pin is synchronized and then filtered so that a new level is accepted only after it has been stable for `CNT_MAX` cycles. Each accepted change is reported with a one-cycle `key_flag` pulse. This block sits between the board pin and every consumer of key events, such as the beeper toggle.

## Interface
- `CNT_MAX`, default 1_000_000: stable cycles required to accept a level (20 ms at 50 MHz); legal range ≥ 2.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `key_in` in 1: raw button pin, asynchronous to `clk`; 0 = pressed.
- `key_value` out 1: debounced level; 0 = pressed, 1 = released.
- `key_flag` out 1: one-cycle pulse coincident with every change of `key_value`.

## Operation
- **Synchronizer:** two flops, both reset to 1, produce `key_s`. The FSM sees only `key_s`, never `key_in`.
- **States:**
  - `IDLE_UP`: stable released, `key_value` = 1.
  - `DEB_DOWN`: qualifying a press.
  - `HELD_DOWN`: stable pressed, `key_value` = 0.
  - `DEB_UP`: qualifying a release.
- **Transitions and counter:**
  - `IDLE_UP` → `DEB_DOWN` when `key_s` = 0; counter loads 0.
  - `DEB_DOWN`, `key_s` = 1: abort to `IDLE_UP`. Counter clears and no flag is raised.
  - `DEB_DOWN`, `key_s` = 0, counter < `CNT_MAX`-1: counter increments.
  - `DEB_DOWN`, `key_s` = 0, counter = `CNT_MAX`-1: go to `HELD_DOWN`. On that same edge `key_value` ← 0, `key_flag` ← 1, and the counter clears.
  - `HELD_DOWN` / `DEB_UP`: symmetric to the above with polarities swapped. An accepted release sets `key_value` ← 1 and pulses `key_flag`.
- **Counter:** width `$clog2(CNT_MAX)`. It must never wrap, because it saturates by construction at `CNT_MAX`-1.
- **Glitches:** any glitch shorter than `CNT_MAX` consecutive cycles produces no change and no flag. A bounce during qualification restarts the count from 0 on the next qualification attempt.
- **Flag behaviour:** `key_flag` is registered and deasserts on the following edge unconditionally. It is never high for two consecutive cycles.
- **Flag/level consistency:** when `key_flag` = 1, `key_value` already holds the new level. A consumer that samples `key_flag && key_value == 0` detects a press exactly once per press.

## Timing
- **Reset values:**
  - `key_value` = 1, `key_flag` = 0.
  - State `IDLE_UP`, counter 0.
  - Both synchronizer flops = 1.
- **Reset mid-operation:** reset asserted in any state forces the values above immediately. No flag is emitted on release from reset, even if the pin is held low; the press is then qualified normally, taking `CNT_MAX`+3 edges.
- **Latency:** take edge 1 as the first rising edge at which the synchronizer's first flop captures the new level. `key_value` changes and `key_flag` rises on edge `CNT_MAX`+3; `key_flag` falls on edge `CNT_MAX`+4.
- **Minimum spacing:** two accepted events are at least `CNT_MAX`+1 cycles apart.
- **Simultaneous events:** a level reversal on the very edge where the count completes is not observed (`key_s` is already stable that cycle). The accepted event stands, and the reversal is qualified from the new stable state.

## Structure
- **Shared package `key_pkg`:**
  - State enum `key_state_t` (`IDLE_UP`, `DEB_DOWN`, `HELD_DOWN`, `DEB_UP`).
  - Constant `KEY_CNT_20MS_50MHZ` = 1_000_000.
  - Constants `KEY_PRESSED` = 0 and `KEY_RELEASED` = 1.
- **Sub-module:** one, `sync_2ff`. It is parameterised by reset value and reusable for other pins.
- **Top level:** FSM, counter and output registers live in `key_debounce`. No other hierarchy.

## Test plan
All scenarios use `CNT_MAX` = 4.
- **Reset:** hold `key_in` = 0 during reset, then release reset → `key_value` = 1, `key_flag` = 0 immediately after reset. `key_value` becomes 0 with a single `key_flag` pulse at edge 7 after reset release.
- **Clean press:** `key_in` 1 → 0 at edge 1 → `key_flag` = 1 only after edge 7 with `key_value` = 0; `key_flag` = 0 after edge 8.
- **Bounce:** `key_in` = 0 for 3 cycles, 1 for 1 cycle, then 0 steadily → no flag during the bounce. Exactly one flag, 7 edges after the last 1 → 0 transition.
- **Glitch rejection:** 1-, 2- and 3-cycle low pulses on `key_in` while released → `key_value` stays 1 and `key_flag` never asserts.
- **Press/release pair:** press held 20 cycles, then released → exactly two flags, with `key_value` 0 then 1. A model consumer toggling on `key_flag && key_value == 0` toggles exactly once.
- **Reset mid-qualification:** assert `rst` while in `DEB_DOWN` with counter = 2 → outputs return to 1/0 asynchronously. No flag appears in the cycle after reset deasserts.
